// File: rtl/fifo_write_arbiter_if.sv
// Write-port bundle between NUM_REQ producers, the arbiter and one FIFO.
// The master modport is the arbiter's view. The slave modport is the view
// of the producers plus the FIFO that surround it.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [DATA_W-1:0]         fifo_x;
    logic                      fifo_insert;
    logic                      fifo_input_ready;

    modport master (
        input  req, req_data, fifo_input_ready,
        output gnt, fifo_x, fifo_insert
    );

    modport slave (
        output req, req_data, fifo_input_ready,
        input  gnt, fifo_x, fifo_insert
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// Each grant issues a one-cycle insert. The arbiter then waits until the FIFO
// drops input_ready. A watchdog sets a sticky err if the word is never taken.
module fifo_write_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_write_arbiter_if.master bus,
    output logic [IDX_W-1:0]     winner,
    output logic                 busy,
    output logic                 err,
    input  logic                 err_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INSERT    = 2'd1,
        WAIT_TAKE = 2'd2
    } state_e;

    localparam int TIMER_W = 8;

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     winner_q, winner_d;
    logic [DATA_W-1:0]    fifo_x_q, fifo_x_d;
    logic                 insert_q, insert_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;

    logic                 pick_found;
    logic [IDX_W-1:0]     pick_idx;

    // Round-robin pick: the first active request after the last winner, with wrap-around.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = winner_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!pick_found && bus.req[(int'(winner_q) + k) % NUM_REQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(winner_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output logic for the IDLE -> INSERT -> WAIT_TAKE cycle.
    always_comb begin
        // NOTE: every signal gets a default here, so no path can infer a latch.
        state_d  = state_q;
        winner_d = winner_q;
        fifo_x_d = fifo_x_q;
        insert_d = 1'b0;
        gnt_d    = '0;
        timer_d  = timer_q;
        err_d    = err_clr ? 1'b0 : err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.fifo_input_ready && pick_found) begin
                    state_d  = INSERT;
                    winner_d = pick_idx;
                    fifo_x_d = bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    insert_d = 1'b1;
                    gnt_d    = NUM_REQ'(1) << pick_idx;
                end
            end
            INSERT: begin
                timer_d = '0;
                state_d = WAIT_TAKE;
            end
            WAIT_TAKE: begin
                if (!bus.fifo_input_ready) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (timer_d == TIMER_W'(TIMEOUT)) begin
                        // The word is abandoned. A set overrides a same-cycle clear.
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers. Reset abandons any in-flight insert.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            winner_q <= IDX_W'(NUM_REQ - 1);
            fifo_x_q <= '0;
            insert_q <= 1'b0;
            gnt_q    <= '0;
            timer_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values.
            state_q  <= state_d;
            winner_q <= winner_d;
            fifo_x_q <= fifo_x_d;
            insert_q <= insert_d;
            gnt_q    <= gnt_d;
            timer_q  <= timer_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.fifo_x      = fifo_x_q;
    assign bus.fifo_insert = insert_q;
    assign winner          = winner_q;
    assign busy            = busy_q;
    assign err             = err_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter. Stimulus pushes the expected grants.
// A negedge monitor pops one entry for every observed insert and compares it.
module tb_fifo_write_arbiter;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;
    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 15;

    typedef struct {
        int         idx;
        logic [3:0] data;
        int         exp_cyc;  // 0 = insert cycle not checked
        int         gap;      // 0 = spacing from the previous insert not checked
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [IDX_W-1:0] winner;
    logic             busy;
    logic             err;
    logic             err_clr;

    fifo_write_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    fifo_write_arbiter #(
        .NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus    (bus),
        .winner (winner),
        .busy   (busy),
        .err    (err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fails = 0;
    int   ins_count = 0;
    int   last_ins_cyc = -100;
    exp_t exp_q[$];
    logic [3:0] pdata [NUM_REQ];
    int   ready_mode;  // 0: held low, 1: held high, 2: FIFO model
    int   hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO model: in mode 2 it takes a word by dropping ready for the cycle after the insert.
    always @(negedge clk) begin
        if (ready_mode == 0) begin
            bus.fifo_input_ready = 1'b0;
            hold = 0;
        end else if (ready_mode == 1) begin
            bus.fifo_input_ready = 1'b1;
            hold = 0;
        end else if (bus.fifo_insert === 1'b1) begin
            bus.fifo_input_ready = 1'b0;
            hold = 1;
        end else if (hold > 0) begin
            bus.fifo_input_ready = 1'b0;
            hold = 0;
        end else begin
            bus.fifo_input_ready = 1'b1;
        end
    end

    // Monitor: compare each insert against the oldest expected entry. Check gnt is quiet otherwise.
    always @(negedge clk) begin
        exp_t e;
        if (bus.fifo_insert === 1'b1) begin
            ins_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_insert", 32'(bus.gnt), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("gnt_onehot", 32'(bus.gnt), 32'(1) << e.idx);
                check("fifo_x", 32'(bus.fifo_x), 32'(e.data));
                check("winner", 32'(winner), 32'(e.idx));
                check("busy_in_insert", 32'(busy), 32'h1);
                if (e.exp_cyc != 0) check("insert_latency_cycle", cyc, e.exp_cyc);
                if (e.gap != 0) check("insert_spacing", cyc - last_ins_cyc, e.gap);
            end
            last_ins_cyc = cyc;
        end else begin
            check("gnt_idle_zero", 32'(bus.gnt), 32'h0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic set_req(input logic [3:0] r);
        bus.req = r;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = pdata[i];
    endtask

    task automatic expect_grant(input int idx, input int exp_cyc, input int gap);
        exp_t e;
        e.idx = idx; e.data = pdata[idx]; e.exp_cyc = exp_cyc; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic wait_inserts(input int n);
        int target = ins_count + n;
        int budget = 80;
        while (ins_count < target && budget > 0) begin
            step(1);
            budget--;
        end
        if (ins_count < target) check("wait_inserts_timeout", ins_count, target);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        pdata[0] = 4'hA; pdata[1] = 4'h6; pdata[2] = 4'h3; pdata[3] = 4'hF;
        ready_mode = 2;
        hold = 0;
        bus.fifo_input_ready = 1'b1;
        err_clr = 1'b0;
        rst_n = 1'b0;
        set_req(4'b1111);

        // Reset values do not depend on the requests that are held during reset.
        step(2);
        check("rst_insert", 32'(bus.fifo_insert), 32'h0);
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_fifo_x", 32'(bus.fifo_x), 32'h0);
        check("rst_winner", 32'(winner), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_err", 32'(err), 32'h0);

        // All four producers request: expect 0,1,2,3,0 with inserts 3 cycles apart.
        expect_grant(0, 0, 0);
        expect_grant(1, 0, 3);
        expect_grant(2, 0, 3);
        expect_grant(3, 0, 3);
        expect_grant(0, 0, 3);
        rst_n = 1'b1;
        wait_inserts(5);
        set_req(4'b0000);
        step(4);

        // A lone producer 2 with data 0x5: insert comes 1 cycle after the sample, then back-to-back grants.
        pdata[2] = 4'h5;
        set_req(4'b0100);
        expect_grant(2, cyc + 1, 0);
        expect_grant(2, 0, 3);
        expect_grant(2, 0, 3);
        wait_inserts(3);
        set_req(4'b0000);
        step(4);

        // Ready is held low: requests wait and no timeout starts. Reset first to restore winner=3.
        ready_mode = 0;
        step(1);
        rst_n = 1'b0;
        set_req(4'b0011);
        step(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("blocked_insert", 32'(bus.fifo_insert), 32'h0);
            check("blocked_busy", 32'(busy), 32'h0);
            check("blocked_err", 32'(err), 32'h0);
        end
        expect_grant(0, 0, 0);
        ready_mode = 2;
        wait_inserts(1);
        set_req(4'b0000);
        step(4);

        // The FIFO never takes the word: err after 15 WAIT_TAKE cycles, then the next producer is served.
        ready_mode = 1;
        step(1);
        expect_grant(1, 0, 0);
        set_req(4'b0011);
        wait_inserts(1);
        t0 = cyc;
        set_req(4'b0001);
        step(15);
        check("wd_err_before", 32'(err), 32'h0);
        check("wd_busy_before", 32'(busy), 32'h1);
        step(1);
        check("wd_err_set", 32'(err), 32'h1);
        check("wd_busy_idle", 32'(busy), 32'h0);
        ready_mode = 2;
        expect_grant(0, t0 + 17, 0);
        wait_inserts(1);
        set_req(4'b0000);
        step(4);
        check("err_sticky", 32'(err), 32'h1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 32'h0);

        // Async reset in the middle of an INSERT cycle drops the outputs without a clock edge.
        set_req(4'b0100);
        expect_grant(2, 0, 0);
        wait_inserts(1);
        rst_n = 1'b0;
        #1;
        check("async_insert", 32'(bus.fifo_insert), 32'h0);
        check("async_gnt", 32'(bus.gnt), 32'h0);
        check("async_busy", 32'(busy), 32'h0);
        set_req(4'b0000);
        step(1);
        rst_n = 1'b1;
        step(1);
        check("post_rst_winner", 32'(winner), 32'h3);
        check("post_rst_busy", 32'(busy), 32'h0);
        check("post_rst_err", 32'(err), 32'h0);

        // With winner=0 and req=1001, the scan wraps: grant 3 first, then 0.
        expect_grant(0, 0, 0);
        set_req(4'b0001);
        wait_inserts(1);
        set_req(4'b0000);
        step(4);
        expect_grant(3, 0, 0);
        expect_grant(0, 0, 3);
        set_req(4'b1001);
        wait_inserts(2);
        set_req(4'b0000);
        step(6);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
